// File: rtl/usb_ep_arbiter.sv
// usb_ep_arbiter: shares the usb core transaction port between NUM_EP endpoint handlers.
// Define USB_EP_NAK_COUNT_EN to add the saturating nak_count output.
module usb_ep_arbiter #(
    parameter int NUM_EP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  usb_rst,
    input  logic                  transaction_active,
    input  logic [3:0]            endpoint,
    input  logic                  direction_in,
    input  logic                  setup,
    input  logic                  success,
    input  logic                  data_strobe,
    input  logic [7:0]            data_out,
    output logic [1:0]            handshake,
    output logic                  data_toggle,
    output logic [7:0]            data_in,
    output logic                  data_in_valid,
    input  logic [8*NUM_EP-1:0]   ep_in_data,
    input  logic [NUM_EP-1:0]     ep_in_valid,
    input  logic [NUM_EP-1:0]     ep_in_avail,
    input  logic [NUM_EP-1:0]     ep_out_ready,
    input  logic [NUM_EP-1:0]     ep_stall,
    input  logic [NUM_EP-1:0]     ep_toggle_clr,
    output logic [NUM_EP-1:0]     ep_in_strobe,
    output logic [NUM_EP-1:0]     ep_out_strobe,
    output logic [7:0]            ep_out_data,
    output logic [NUM_EP-1:0]     ep_setup,
    output logic [NUM_EP-1:0]     ep_done,
    output logic [NUM_EP-1:0]     ep_active
`ifdef USB_EP_NAK_COUNT_EN
    ,output logic [15:0]          nak_count
`endif
);
    typedef enum logic [1:0] {IDLE, SELECT, ACTIVE} state_t;
    state_t state;
    logic ta_q, dir_q, act, ack, fire, tog_sel;
    logic [1:0] hs_sel;
    logic [NUM_EP-1:0] toggle, toggle_sel, toggle_nxt, oh;
    // oh is all-zero for an out-of-range endpoint, which makes every per-ep path inert
    always_comb begin
        oh = '0;
        for (int i = 0; i < NUM_EP; i++) oh[i] = endpoint == 4'(i);
        hs_sel = ~|oh ? 2'b11 :
                 setup ? 2'b00 :
                 |(oh & ep_stall) ? 2'b11 :
                 direction_in ? (|(oh & ep_in_avail) ? 2'b00 : 2'b10) :
                 (|(oh & ep_out_ready) ? 2'b00 : 2'b10);
        tog_sel = !setup && |(oh & toggle);
    end
    assign act = state == ACTIVE;
    assign ack = handshake == 2'b00;
    assign fire = act && success && ack;
    assign toggle_sel = (state == SELECT && setup) ? toggle & ~oh : toggle;
    assign toggle_nxt = (fire ? toggle_sel ^ ep_active : toggle_sel) & ~ep_toggle_clr;
    assign ep_in_strobe = {NUM_EP{data_strobe && act && dir_q && ack}} & ep_active;
    assign ep_out_strobe = {NUM_EP{data_strobe && act && !dir_q && ack}} & ep_active;
    assign ep_out_data = data_out;
    always_comb begin
        data_in = '0;
        for (int i = 0; i < NUM_EP; i++) data_in = ep_active[i] ? ep_in_data[8*i +: 8] : data_in;
        data_in_valid = act && dir_q && ack && |(ep_active & ep_in_valid);
    end
    always_ff @(posedge clk) begin
        ta_q <= transaction_active;
        if (!rst || usb_rst) begin
            state       <= IDLE;
            dir_q       <= 1'b0;
            toggle      <= '0;
            handshake   <= 2'b01;
            data_toggle <= 1'b0;
            ep_active   <= '0;
            ep_setup    <= '0;
            ep_done     <= '0;
`ifdef USB_EP_NAK_COUNT_EN
            nak_count   <= '0;
`endif
        end else begin
            toggle   <= toggle_nxt;
            ep_setup <= '0;
            ep_done  <= fire ? ep_active : '0;
            case (state)
                IDLE: if (transaction_active && !ta_q) state <= SELECT;
                SELECT: begin
                    dir_q       <= direction_in;
                    handshake   <= hs_sel;
                    data_toggle <= tog_sel;
                    ep_active   <= oh;
                    ep_setup    <= setup ? oh : '0;
                    state       <= ACTIVE;
`ifdef USB_EP_NAK_COUNT_EN
                    if (hs_sel == 2'b10 && nak_count != 16'hFFFF) nak_count <= nak_count + 16'd1;
`endif
                end
                ACTIVE: if (!transaction_active) begin
                    handshake <= 2'b01;
                    ep_active <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_ep_arbiter.sv
// tb_usb_ep_arbiter: directed and randomized transactions against a rule-level endpoint model.
module tb_usb_ep_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst, usb_rst, transaction_active, direction_in, setup, success, data_strobe;
    logic [3:0] endpoint;
    logic [7:0] data_out, data_in, ep_out_data;
    logic [1:0] handshake;
    logic data_toggle, data_in_valid;
    logic [8*N-1:0] ep_in_data;
    logic [N-1:0] ep_in_valid, ep_in_avail, ep_out_ready, ep_stall, ep_toggle_clr;
    logic [N-1:0] ep_in_strobe, ep_out_strobe, ep_setup, ep_done, ep_active;
`ifdef USB_EP_NAK_COUNT_EN
    logic [15:0] nak_count;
    int m_nak = 0;
`endif
    int errors = 0, checks = 0;
    bit m_tog[N];

    usb_ep_arbiter #(.NUM_EP(N)) dut (
        .clk(clk), .rst(rst), .usb_rst(usb_rst), .transaction_active(transaction_active),
        .endpoint(endpoint), .direction_in(direction_in), .setup(setup), .success(success),
        .data_strobe(data_strobe), .data_out(data_out), .handshake(handshake),
        .data_toggle(data_toggle), .data_in(data_in), .data_in_valid(data_in_valid),
        .ep_in_data(ep_in_data), .ep_in_valid(ep_in_valid), .ep_in_avail(ep_in_avail),
        .ep_out_ready(ep_out_ready), .ep_stall(ep_stall), .ep_toggle_clr(ep_toggle_clr),
        .ep_in_strobe(ep_in_strobe), .ep_out_strobe(ep_out_strobe), .ep_out_data(ep_out_data),
        .ep_setup(ep_setup), .ep_done(ep_done), .ep_active(ep_active)
`ifdef USB_EP_NAK_COUNT_EN
        , .nak_count(nak_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_hs(int ep, bit dir, bit stp);
        if (ep >= N) return 2'b11;
        if (stp) return 2'b00;
        if (ep_stall[ep]) return 2'b11;
        if (dir) return ep_in_avail[ep] ? 2'b00 : 2'b10;
        return ep_out_ready[ep] ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [N-1:0] onehot(int ep);
        logic [N-1:0] r = '0;
        if (ep < N) r[ep] = 1'b1;
        return r;
    endfunction

    task automatic txn(input int ep, input bit dir, input bit stp, input int nb, input bit succ,
                       input logic [N-1:0] clr, input logic [63:0] pay);
        logic [1:0] hs;
        logic [N-1:0] oh;
        logic [7:0] b;
        bit ok, ack;
        ok = ep < N;
        oh = onehot(ep);
        hs = exp_hs(ep, dir, stp);
        ack = hs == 2'b00;
        endpoint = 4'(ep);
        direction_in = dir;
        setup = stp;
        transaction_active = 1'b1;
        tick();
        tick();
        chk("handshake", 32'(handshake), 32'(hs));
        chk("data_toggle", 32'(data_toggle), (ok && !stp) ? 32'(m_tog[ep]) : 32'd0);
        chk("ep_active", 32'(ep_active), 32'(oh));
        chk("ep_setup", 32'(ep_setup), stp ? 32'(oh) : 32'd0);
        if (ok && stp) m_tog[ep] = 1'b0;
`ifdef USB_EP_NAK_COUNT_EN
        if (hs == 2'b10 && m_nak < 16'hFFFF) m_nak++;
`endif
        for (int k = 0; k < nb; k++) begin
            b = pay[63-8*k -: 8];
            data_out = b;
            ep_in_data = $urandom;
            ep_in_valid = N'($urandom);
            data_strobe = 1'b1;
            #1;
            chk("ep_out_data", 32'(ep_out_data), 32'(b));
            chk("ep_out_strobe", 32'(ep_out_strobe), (ack && !dir) ? 32'(oh) : 32'd0);
            chk("ep_in_strobe", 32'(ep_in_strobe), (ack && dir) ? 32'(oh) : 32'd0);
            chk("data_in_valid", 32'(data_in_valid), (ack && dir && ok) ? 32'(ep_in_valid[ep]) : 32'd0);
            if (ok) chk("data_in", 32'(data_in), 32'(ep_in_data[8*ep +: 8]));
            tick();
            data_strobe = 1'b0;
        end
        if (succ) begin
            success = 1'b1;
            ep_toggle_clr = clr;
            tick();
            success = 1'b0;
            ep_toggle_clr = '0;
            chk("ep_done", 32'(ep_done), ack ? 32'(oh) : 32'd0);
            if (ack && ok) m_tog[ep] = !m_tog[ep];
            for (int i = 0; i < N; i++) if (clr[i]) m_tog[i] = 1'b0;
        end
        transaction_active = 1'b0;
        tick();
        chk("handshake_idle", 32'(handshake), 32'd1);
        chk("ep_active_idle", 32'(ep_active), 32'd0);
        chk("ep_done_pulse", 32'(ep_done), 32'd0);
`ifdef USB_EP_NAK_COUNT_EN
        chk("nak_count", 32'(nak_count), 32'(m_nak));
`endif
        tick();
    endtask

    task automatic clr_idle(input logic [N-1:0] c);
        ep_toggle_clr = c;
        tick();
        ep_toggle_clr = '0;
        for (int i = 0; i < N; i++) if (c[i]) m_tog[i] = 1'b0;
    endtask

    task automatic rst_mid(input bit use_usb);
        endpoint = 4'd1;
        direction_in = 1'b1;
        setup = 1'b0;
        ep_stall = '0;
        ep_in_avail = 4'b0010;
        transaction_active = 1'b1;
        tick();
        tick();
        chk("rst_pre_hs", 32'(handshake), 32'd0);
        success = 1'b1;
        if (use_usb) usb_rst = 1'b1; else rst = 1'b0;
        tick();
        success = 1'b0;
        rst = 1'b1;
        usb_rst = 1'b0;
        for (int i = 0; i < N; i++) m_tog[i] = 1'b0;
`ifdef USB_EP_NAK_COUNT_EN
        m_nak = 0;
`endif
        chk("rst_hs", 32'(handshake), 32'd1);
        chk("rst_active", 32'(ep_active), 32'd0);
        chk("rst_done", 32'(ep_done), 32'd0);
        chk("rst_toggle", 32'(data_toggle), 32'd0);
        transaction_active = 1'b0;
        tick();
        chk("rst_done_after", 32'(ep_done), 32'd0);
        tick();
        for (int e = 0; e < N; e++) txn(e, 1'b1, 1'b0, 0, 1'b0, '0, 64'd0);
    endtask

    initial begin
        rst = 1'b0; usb_rst = 1'b0; transaction_active = 1'b0; endpoint = '0;
        direction_in = 1'b0; setup = 1'b0; success = 1'b0; data_strobe = 1'b0; data_out = '0;
        ep_in_data = '0; ep_in_valid = '0; ep_in_avail = '0; ep_out_ready = '0;
        ep_stall = '0; ep_toggle_clr = '0;
        repeat (3) tick();
        chk("reset_hs", 32'(handshake), 32'd1);
        chk("reset_toggle", 32'(data_toggle), 32'd0);
        chk("reset_active", 32'(ep_active), 32'd0);
        chk("reset_pulses", 32'({ep_setup, ep_done}), 32'd0);
        rst = 1'b1;
        tick();
        txn(0, 1'b0, 1'b1, 8, 1'b1, '0, 64'h8006_0001_0000_1200);
        ep_in_avail = 4'b0010;
        txn(1, 1'b1, 1'b0, 4, 1'b1, '0, {$urandom, $urandom});
        txn(0, 1'b1, 1'b0, 0, 1'b0, '0, 64'd0);
        txn(1, 1'b1, 1'b0, 0, 1'b0, '0, 64'd0);
        txn(2, 1'b1, 1'b0, 3, 1'b1, '0, {$urandom, $urandom});
        txn(2, 1'b1, 1'b0, 0, 1'b0, '0, 64'd0);
        ep_out_ready = 4'b1111;
        txn(5, 1'b0, 1'b0, 2, 1'b1, '0, {$urandom, $urandom});
        ep_stall = 4'b1000;
        txn(3, 1'b0, 1'b0, 2, 1'b1, '0, {$urandom, $urandom});
        txn(3, 1'b0, 1'b1, 2, 1'b1, '0, {$urandom, $urandom});
        ep_stall = '0;
        txn(1, 1'b1, 1'b0, 1, 1'b1, 4'b0010, {$urandom, $urandom});
        txn(1, 1'b1, 1'b0, 0, 1'b0, '0, 64'd0);
        success = 1'b1;
        tick();
        success = 1'b0;
        txn(3, 1'b0, 1'b0, 0, 1'b0, '0, 64'd0);
        for (int n = 0; n < 80; n++) begin
            ep_stall = N'($urandom) & N'($urandom);
            ep_in_avail = N'($urandom);
            ep_out_ready = N'($urandom);
            if ($urandom_range(0, 5) == 0) clr_idle(N'($urandom));
            txn($urandom_range(0, 6), 1'($urandom), $urandom_range(0, 7) == 0,
                $urandom_range(0, 4), 1'($urandom | $urandom),
                ($urandom_range(0, 3) == 0) ? N'($urandom) : '0, {$urandom, $urandom});
        end
        ep_stall = '0;
        ep_in_avail = 4'b0010;
        txn(0, 1'b0, 1'b1, 1, 1'b1, '0, {$urandom, $urandom});
        if (!m_tog[1]) txn(1, 1'b1, 1'b0, 1, 1'b1, '0, {$urandom, $urandom});
        rst_mid(1'b0);
        ep_in_avail = 4'b0011;
        txn(0, 1'b1, 1'b0, 1, 1'b1, '0, {$urandom, $urandom});
        txn(1, 1'b1, 1'b0, 1, 1'b1, '0, {$urandom, $urandom});
        rst_mid(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
